// File: rtl/lenet_pkg.sv
// lenet_pkg: layer-state codes, layer class codes and shared widths for the LeNet datapath.
// Rev 1.0
`default_nettype none

package lenet_pkg;

  localparam int AK_BW    = 20;
  localparam int ACC_LINE = 5;
  localparam int OUT_BW   = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_C1   = 3'd1;
  localparam logic [2:0] S_S2   = 3'd2;
  localparam logic [2:0] S_C3   = 3'd3;
  localparam logic [2:0] S_S4   = 3'd4;
  localparam logic [2:0] S_C5   = 3'd5;

  localparam logic [1:0] CLS_NONE = 2'd0;
  localparam logic [1:0] CLS_CONV = 2'd1;
  localparam logic [1:0] CLS_SUB  = 2'd2;

  function automatic logic [1:0] layer_class(input logic [2:0] ls);
    logic [1:0] cls;
    cls = CLS_NONE;
    case (ls)
      S_C1, S_C3, S_C5: cls = CLS_CONV;
      S_S2, S_S4:       cls = CLS_SUB;
      default:          cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/psum_sat_relu.sv
// psum_sat_relu: arithmetic right shift, optional ReLU and signed saturation to OUT_BW.
// Rev 1.0
`default_nettype none

module psum_sat_relu #(
  parameter int IN_BW  = 32,
  parameter int SHIFT  = 8,
  parameter int OUT_BW = 16
) (
  input  logic signed [IN_BW-1:0]  din,
  input  logic                     relu_en,
  output logic signed [OUT_BW-1:0] dout
);

  localparam logic signed [IN_BW-1:0] MAX_V = {{(IN_BW-OUT_BW+1){1'b0}}, {(OUT_BW-1){1'b1}}};
  localparam logic signed [IN_BW-1:0] MIN_V = {{(IN_BW-OUT_BW+1){1'b1}}, {(OUT_BW-1){1'b0}}};

  logic signed [IN_BW-1:0] shifted;
  logic signed [IN_BW-1:0] clamped;

  always_comb begin
    shifted = din >>> SHIFT;
    clamped = shifted;
    if (relu_en && shifted < 0)
      clamped = '0;
    else if (shifted > MAX_V)
      clamped = MAX_V;
    else if (shifted < MIN_V)
      clamped = MIN_V;
  end

  assign dout = clamped[OUT_BW-1:0];

endmodule

`default_nettype wire

// File: rtl/psum_channel_post.sv
// psum_channel_post: reduces row partial sums, accumulates across channels, adds bias,
// rescales/ReLU/saturates and emits the pixel over valid/ready. Rev 1.0
`default_nettype none

module psum_channel_post
  import lenet_pkg::*;
#(
  parameter int AK_BW_P    = AK_BW,
  parameter int ACC_LINE_P = ACC_LINE,
  parameter int PS_BW      = 32,
  parameter int BIAS_BW    = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_BW_P   = OUT_BW,
  parameter int MAX_CH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    i_layer_state,
  input  logic                          i_start,
  input  logic [4:0]                    i_num_ch,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [AK_BW_P*ACC_LINE_P-1:0] i_acc_kernel,
  input  logic [BIAS_BW-1:0]            i_bias,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [OUT_BW_P-1:0]           o_data,
  output logic                          o_busy,
  output logic                          o_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_BIAS  = 3'd2,
    ST_POST  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  state_t                      state, state_nxt;
  logic signed [PS_BW-1:0]     acc, acc_nxt;
  logic [4:0]                  cnt, cnt_nxt;
  logic [4:0]                  num_ch, num_ch_nxt;
  logic                        is_conv, is_conv_nxt;
  logic                        out_valid, out_valid_nxt;
  logic [OUT_BW_P-1:0]         out_data, out_data_nxt;
  logic                        err_pulse, err_pulse_nxt;

  logic signed [PS_BW-1:0]     rowsum;
  logic signed [PS_BW-1:0]     bias_ext;
  logic signed [OUT_BW_P-1:0]  post_val;
  logic                        start_ok;
  logic                        take_start;

  always_comb begin
    rowsum = '0;
    for (int l = 0; l < ACC_LINE_P; l++) begin
      rowsum = rowsum + {{(PS_BW-AK_BW_P){i_acc_kernel[l*AK_BW_P+AK_BW_P-1]}},
                         i_acc_kernel[l*AK_BW_P +: AK_BW_P]};
    end
  end

  assign bias_ext = {{(PS_BW-BIAS_BW){i_bias[BIAS_BW-1]}}, i_bias};

  psum_sat_relu #(
    .IN_BW  (PS_BW),
    .SHIFT  (FRAC_SHIFT),
    .OUT_BW (OUT_BW_P)
  ) u_sat (
    .din     (acc),
    .relu_en (is_conv),
    .dout    (post_val)
  );

  // A start is only taken in IDLE or on the OUT handshake cycle; any other start is an error.
  assign start_ok   = i_start && (layer_class(i_layer_state) != CLS_NONE) &&
                      (i_num_ch != 5'd0) && (i_num_ch <= 5'(MAX_CH));
  assign take_start = start_ok && ((state == ST_IDLE) || (state == ST_OUT && i_ready));

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    num_ch_nxt    = num_ch;
    is_conv_nxt   = is_conv;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    err_pulse_nxt = i_start && !take_start;

    if (take_start) begin
      acc_nxt     = '0;
      cnt_nxt     = '0;
      num_ch_nxt  = i_num_ch;
      is_conv_nxt = (layer_class(i_layer_state) == CLS_CONV);
    end

    case (state)
      ST_IDLE: begin
        if (take_start)
          state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (i_valid) begin
          acc_nxt = acc + rowsum;
          cnt_nxt = cnt + 5'd1;
          if (cnt == num_ch - 5'd1)
            state_nxt = ST_BIAS;
        end
      end
      ST_BIAS: begin
        acc_nxt   = acc + bias_ext;
        state_nxt = ST_POST;
      end
      ST_POST: begin
        out_data_nxt  = post_val;
        out_valid_nxt = 1'b1;
        state_nxt     = ST_OUT;
      end
      ST_OUT: begin
        if (i_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = take_start ? ST_ACCUM : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      num_ch    <= '0;
      is_conv   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      num_ch    <= num_ch_nxt;
      is_conv   <= is_conv_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      err_pulse <= err_pulse_nxt;
    end
  end

  assign o_ready = (state == ST_ACCUM);
  assign o_busy  = (state != ST_IDLE);
  assign o_valid = out_valid;
  assign o_data  = out_data;
  assign o_err   = err_pulse;

endmodule

`default_nettype wire

// File: tb/tb_psum_channel_post.sv
// tb_psum_channel_post: directed scoreboard bench for psum_channel_post.
// Rev 1.0
`default_nettype none

module tb_psum_channel_post;

  logic         clk;
  logic         rst;
  logic [2:0]   i_layer_state;
  logic         i_start;
  logic [4:0]   i_num_ch;
  logic         i_valid;
  logic         o_ready;
  logic [99:0]  i_acc_kernel;
  logic [15:0]  i_bias;
  logic         o_valid;
  logic         i_ready;
  logic [15:0]  o_data;
  logic         o_busy;
  logic         o_err;

  int total = 0;
  int bad   = 0;
  logic signed [31:0] sb[$];

  psum_channel_post dut (
    .clk           (clk),
    .rst           (rst),
    .i_layer_state (i_layer_state),
    .i_start       (i_start),
    .i_num_ch      (i_num_ch),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_acc_kernel  (i_acc_kernel),
    .i_bias        (i_bias),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_data        (o_data),
    .o_busy        (o_busy),
    .o_err         (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] model(input int layer, input longint sum);
    longint v;
    logic signed [63:0] r;
    v = sum >>> 8;
    if ((layer == 1 || layer == 3 || layer == 5) && v < 0) v = 0;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    r = v;
    return r[31:0];
  endfunction

  task automatic do_start(input int layer, input int nch, input int bias);
    i_layer_state = layer[2:0];
    i_num_ch      = nch[4:0];
    i_bias        = bias[15:0];
    i_start       = 1'b1;
    @(negedge clk);
    i_start       = 1'b0;
    i_layer_state = 3'd7;
  endtask

  task automatic beat(input int lane);
    for (int l = 0; l < 5; l++) i_acc_kernel[l*20 +: 20] = lane[19:0];
    i_valid = 1'b1;
    for (int k = 0; k < 50 && !o_ready; k++) @(negedge clk);
    chk("beat_ready", {31'd0, o_ready}, 1);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    logic signed [31:0] exp;
    for (int k = 0; k < 50 && !o_valid; k++) @(negedge clk);
    chk({tag, "_valid"}, {31'd0, o_valid}, 1);
    exp = 32'sd0;
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
    else exp = sb.pop_front();
    chk({tag, "_data"}, $signed(o_data), exp);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, o_valid}, 0);
    chk({tag, "_data_hold"}, $signed(o_data), exp);
  endtask

  task automatic pixel(input string tag, input int layer, input int nch, input int lane, input int bias);
    do_start(layer, nch, bias);
    for (int b = 0; b < nch; b++) beat(lane);
    sb.push_back(model(layer, longint'(nch) * 5 * lane + bias));
    collect(tag);
  endtask

  initial begin
    rst = 1'b1; i_layer_state = 3'd0; i_start = 1'b0; i_num_ch = 5'd0;
    i_valid = 1'b0; i_acc_kernel = '0; i_bias = '0; i_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, o_ready}, 0);
    chk("rst_valid", {31'd0, o_valid}, 0);
    chk("rst_data", $signed(o_data), 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_err", {31'd0, o_err}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single channel, latency check
    do_start(1, 1, 256);
    chk("t1_busy", {31'd0, o_busy}, 1);
    beat(256);
    sb.push_back(model(1, 1280 + 256));
    chk("t1_lat0", {31'd0, o_valid}, 0);
    @(negedge clk);
    chk("t1_lat1", {31'd0, o_valid}, 0);
    @(negedge clk);
    chk("t1_lat2", {31'd0, o_valid}, 1);
    collect("t1");
    chk("t1_idle", {31'd0, o_busy}, 0);

    // 2: ReLU vs floor on negative sum
    pixel("t2_c3", 3, 6, -100, 0);
    pixel("t2_s2", 2, 6, -100, 0);

    // 3: saturation
    pixel("t3_pos", 5, 16, 524287, 0);
    pixel("t3_neg", 4, 16, -524288, 0);

    // 4: back-pressure then back-to-back restart
    do_start(1, 1, 256);
    beat(256);
    sb.push_back(model(1, 1536));
    for (int k = 0; k < 50 && !o_valid; k++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("t4_stall_valid", {31'd0, o_valid}, 1);
      chk("t4_stall_data", $signed(o_data), 6);
      chk("t4_stall_ready", {31'd0, o_ready}, 0);
      @(negedge clk);
    end
    chk("t4_pop", sb.pop_front(), $signed(o_data));
    i_ready = 1'b1; i_start = 1'b1; i_layer_state = 3'd1; i_num_ch = 5'd1; i_bias = 16'd0;
    @(negedge clk);
    i_ready = 1'b0; i_start = 1'b0; i_layer_state = 3'd7;
    chk("t4_restart_valid", {31'd0, o_valid}, 0);
    chk("t4_restart_ready", {31'd0, o_ready}, 1);
    chk("t4_restart_err", {31'd0, o_err}, 0);
    beat(512);
    sb.push_back(model(1, 2560));
    collect("t4_second");

    // 5: gapped beats
    do_start(3, 6, 100);
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      beat(300);
    end
    chk("t5_no_extra", {31'd0, o_ready}, 0);
    sb.push_back(model(3, 6 * 5 * 300 + 100));
    collect("t5_gap");

    // 5b: reset mid-accumulation
    do_start(2, 6, 0);
    beat(1000); beat(1000); beat(1000);
    rst = 1'b1;
    #1;
    chk("t5_rst_ready", {31'd0, o_ready}, 0);
    chk("t5_rst_busy", {31'd0, o_busy}, 0);
    chk("t5_rst_data", $signed(o_data), 0);
    chk("t5_rst_valid", {31'd0, o_valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pixel("t5_after_rst", 2, 2, 2000, 0);

    // 6: protocol errors
    do_start(0, 1, 0);
    chk("t6_l0_err", {31'd0, o_err}, 1);
    chk("t6_l0_busy", {31'd0, o_busy}, 0);
    @(negedge clk);
    chk("t6_l0_pulse", {31'd0, o_err}, 0);
    do_start(1, 0, 0);
    chk("t6_n0_err", {31'd0, o_err}, 1);
    chk("t6_n0_busy", {31'd0, o_busy}, 0);
    do_start(1, 17, 0);
    chk("t6_n17_err", {31'd0, o_err}, 1);
    chk("t6_n17_busy", {31'd0, o_busy}, 0);
    do_start(6, 2, 0);
    chk("t6_l6_err", {31'd0, o_err}, 1);
    @(negedge clk);
    chk("t6_clear", {31'd0, o_err}, 0);

    do_start(1, 2, 0);
    beat(-100);
    do_start(2, 1, 0);
    chk("t6_accum_err", {31'd0, o_err}, 1);
    chk("t6_accum_ready", {31'd0, o_ready}, 1);
    beat(-100);
    sb.push_back(model(1, -1000));
    collect("t6_unaffected");

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
